// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard-control bundle between pipeline datapath and pipe_ctrl.
// master = datapath side (drives hazard info, receives stall/flush)
// slave  = controller side (receives hazard info, drives stall/flush)
interface pipe_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [1:0] id_uses_rs;
    logic       id_is_csr;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       stall_fd;
    logic       flush_fd;
    logic       stall_de;
    logic       flush_de;
    logic       stall_em;
    logic       stall_mw;
    logic       stall_pc;

    modport master (
        output id_rs1, id_rs2, id_uses_rs, id_is_csr, ex_rd, ex_is_load, ex_redirect, mem_req, mem_ready,
        input  stall_fd, flush_fd, stall_de, flush_de, stall_em, stall_mw, stall_pc
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs, id_is_csr, ex_rd, ex_is_load, ex_redirect, mem_req, mem_ready,
        output stall_fd, flush_fd, stall_de, flush_de, stall_em, stall_mw, stall_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline hazard controller (mem wait, redirect, CSR drain, load-use).
// Ports: clk, nrst (sync active-low), pif (pipe_ctrl_if.slave: hazard inputs, stall/flush outputs).
// Optional macro PIPE_CTRL_PERF_EN adds perf_stall_cycles / perf_flush_events (32-bit, saturating).
module pipe_ctrl #(
    parameter int CSR_DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              nrst,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_events,
`endif
    pipe_ctrl_if.slave        pif
);
    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(CSR_DRAIN_CYCLES);

    state_t     state, state_nxt, state_eff;
    logic [3:0] cnt, cnt_nxt, cnt_eff;
    logic       csr_done, csr_done_nxt, csr_done_eff;
    logic       mem_wait, load_use;
    logic       stall_pc, stall_fd, stall_de, stall_em, stall_mw, flush_fd, flush_de;

    // While nrst is low the outputs follow the RUN-state function, so any
    // in-flight drain leaves no residual bubbles even before the reset edge.
    assign state_eff    = nrst ? state : RUN;
    assign cnt_eff      = nrst ? cnt : 4'd0;
    assign csr_done_eff = nrst && csr_done;

    assign mem_wait = pif.mem_req && !pif.mem_ready;
    assign load_use = pif.ex_is_load && (pif.ex_rd != 5'd0) &&
                      ((pif.id_uses_rs[0] && (pif.id_rs1 == pif.ex_rd)) ||
                       (pif.id_uses_rs[1] && (pif.id_rs2 == pif.ex_rd)));

    // csr_done marks the single cycle after a drain completes: the CSR op is
    // still sitting in decode and must be let through instead of re-draining.
    always_comb begin
        state_nxt    = state_eff;
        cnt_nxt      = cnt_eff;
        csr_done_nxt = 1'b0;
        stall_pc     = 1'b0;
        stall_fd     = 1'b0;
        stall_de     = 1'b0;
        stall_em     = 1'b0;
        stall_mw     = 1'b0;
        flush_fd     = 1'b0;
        flush_de     = 1'b0;
        if (mem_wait) begin
            stall_pc     = 1'b1;
            stall_fd     = 1'b1;
            stall_de     = 1'b1;
            stall_em     = 1'b1;
            stall_mw     = 1'b1;
            csr_done_nxt = csr_done_eff;
        end else if (pif.ex_redirect) begin
            flush_fd  = 1'b1;
            flush_de  = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
        end else if (state_eff == DRAIN) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_de = 1'b1;
            if (cnt_eff <= 4'd1) begin
                state_nxt    = RUN;
                cnt_nxt      = 4'd0;
                csr_done_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_eff - 4'd1;
            end
        end else if (pif.id_is_csr && !csr_done_eff) begin
            // The drain bubbles also cover any concurrent load-use hazard.
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            flush_de  = 1'b1;
            state_nxt = DRAIN;
            cnt_nxt   = DRAIN_INIT;
        end else if (load_use) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_de = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= RUN;
            cnt      <= 4'd0;
            csr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            csr_done <= csr_done_nxt;
        end
    end

    assign pif.stall_pc = stall_pc;
    assign pif.stall_fd = stall_fd;
    assign pif.stall_de = stall_de;
    assign pif.stall_em = stall_em;
    assign pif.stall_mw = stall_mw;
    assign pif.flush_fd = flush_fd;
    assign pif.flush_de = flush_de;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_events <= 32'd0;
        end else begin
            if (stall_fd && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (pif.ex_redirect && !mem_wait && (perf_flush_events != 32'hFFFF_FFFF))
                perf_flush_events <= perf_flush_events + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (CSR_DRAIN_CYCLES = 3).
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    pipe_ctrl_if pif();
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

    pipe_ctrl #(.CSR_DRAIN_CYCLES(3)) dut (
        .clk(clk),
        .nrst(nrst),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_events(perf_flush_events),
`endif
        .pif(pif)
    );

    // Output vector order: {stall_pc, stall_fd, stall_de, stall_em, stall_mw, flush_fd, flush_de}
    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] STL  = 7'b1100001;
    localparam logic [6:0] MW   = 7'b1111100;
    localparam logic [6:0] RD   = 7'b0000011;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        pif.id_rs1      = 5'd0;
        pif.id_rs2      = 5'd0;
        pif.id_uses_rs  = 2'b00;
        pif.id_is_csr   = 1'b0;
        pif.ex_rd       = 5'd0;
        pif.ex_is_load  = 1'b0;
        pif.ex_redirect = 1'b0;
        pif.mem_req     = 1'b0;
        pif.mem_ready   = 1'b0;
    endtask

    // Inputs are already driven; queue the expectation, compare mid-cycle, advance.
    task automatic cyc(input string tag, input logic [6:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        #4;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {25'd0, pif.stall_pc, pif.stall_fd, pif.stall_de, pif.stall_em,
                          pif.stall_mw, pif.flush_fd, pif.flush_de}, {25'd0, e.exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [1:0] uses);
        pif.ex_is_load = 1'b1;
        pif.ex_rd      = rd;
        pif.id_rs1     = rs1;
        pif.id_rs2     = rs2;
        pif.id_uses_rs = uses;
    endtask

    initial begin
        nrst = 1'b0;
        clr();
        @(posedge clk);
        #1;
        cyc("reset_idle", IDLE);
        nrst = 1'b1;
        cyc("run_idle", IDLE);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_rst", perf_stall_cycles, 32'd0);
        check("perf_flush_rst", perf_flush_events, 32'd0);
`endif
        // Load-use
        set_lu(5'd5, 5'd0, 5'd5, 2'b10);
        cyc("lu_rs2", STL);
        clr();
        cyc("lu_release", IDLE);
        set_lu(5'd0, 5'd0, 5'd0, 2'b10);
        cyc("lu_rd0", IDLE);
        set_lu(5'd7, 5'd7, 5'd3, 2'b10);
        cyc("lu_rs1_unused", IDLE);
        set_lu(5'd7, 5'd7, 5'd3, 2'b01);
        cyc("lu_rs1", STL);
        pif.ex_is_load = 1'b0;
        cyc("lu_not_load", IDLE);
        clr();
        // CSR drain with the CSR held in decode
        pif.id_is_csr = 1'b1;
        cyc("csr_c0", STL);
        cyc("csr_c1", STL);
        cyc("csr_c2", STL);
        cyc("csr_c3", STL);
        cyc("csr_release", IDLE);
        clr();
        cyc("csr_after", IDLE);
        // CSR with load-use, then memory wait mid-drain
        pif.id_is_csr = 1'b1;
        set_lu(5'd9, 5'd9, 5'd0, 2'b01);
        cyc("csr_lu_c0", STL);
        pif.ex_is_load = 1'b0;
        cyc("csr_lu_c1", STL);
        pif.mem_req = 1'b1;
        for (int i = 0; i < 6; i++) cyc($sformatf("memwait_%0d", i), MW);
        pif.mem_ready = 1'b1;
        cyc("resume_c2", STL);
        pif.mem_req = 1'b0;
        cyc("resume_c3", STL);
        cyc("resume_release", IDLE);
        clr();
        // Redirect
        set_lu(5'd4, 5'd4, 5'd0, 2'b01);
        pif.ex_redirect = 1'b1;
        cyc("redir_lu", RD);
        clr();
        cyc("redir_after", IDLE);
        pif.id_is_csr = 1'b1;
        cyc("redir_d_c0", STL);
        cyc("redir_d_c1", STL);
        pif.ex_redirect = 1'b1;
        cyc("redir_in_drain", RD);
        clr();
        cyc("redir_back_run", IDLE);
        // Memory wait beats redirect
        pif.ex_redirect = 1'b1;
        pif.mem_req     = 1'b1;
        cyc("memwait_redir", MW);
        clr();
        pif.mem_req   = 1'b1;
        pif.mem_ready = 1'b1;
        cyc("mem_ready", IDLE);
        clr();
        // Reset mid-drain
        pif.id_is_csr = 1'b1;
        cyc("rst_d_c0", STL);
        pif.id_is_csr = 1'b0;
        cyc("rst_d_c1", STL);
        nrst = 1'b0;
        cyc("rst_in_drain", IDLE);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_clr", perf_stall_cycles, 32'd0);
        check("perf_flush_clr", perf_flush_events, 32'd0);
`endif
        nrst = 1'b1;
        cyc("rst_after", IDLE);
`ifdef PIPE_CTRL_PERF_EN
        set_lu(5'd2, 5'd2, 5'd0, 2'b01);
        cyc("perf_lu", STL);
        clr();
        pif.ex_redirect = 1'b1;
        cyc("perf_redir", RD);
        clr();
        check("perf_stall_one", perf_stall_cycles, 32'd1);
        check("perf_flush_one", perf_flush_events, 32'd1);
`endif
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CSR_DRAIN_CYCLES, default 3, bubbles inserted ahead of a decoded CSR op (range 1..15).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 nrst  in  1  reset; synchronous, active-low.
REQ-004 id_rs1, id_rs2  in  5 each  decode-stage source register indices.
REQ-005 id_uses_rs  in  2  bit0 = decode reads rs1, bit1 = decode reads rs2.
REQ-006 id_is_csr  in  1  decode-stage instruction is a CSR op.
REQ-007 ex_rd  in  5  execute-stage destination register.
REQ-008 ex_is_load  in  1  execute-stage instruction is a load.
REQ-009 ex_redirect  in  1  execute-stage taken branch/jump; PC redirect this cycle.
REQ-010 mem_req, mem_ready  in  1 each  memory-stage data access pending / completed.
REQ-011 stall_fd, flush_fd  out  1 each  hold / clear fetch-decode register.
REQ-012 stall_de, flush_de  out  1 each  hold / clear decode-execute register.
REQ-013 stall_em, stall_mw  out  1 each  hold execute-memory / memory-writeback registers.
REQ-014 stall_pc  out  1  hold the PC register.

Function
REQ-015 Outputs are combinational in current inputs and registered state; zero-cycle latency from hazard to stall/flush.
REQ-016 State machine states: RUN, DRAIN; 4-bit drain counter.
REQ-017 mem_wait = mem_req && !mem_ready; when 1: all stall_* = 1, all flush_* = 0, state and counter hold; priority over every other rule.
REQ-018 Redirect (ex_redirect, no mem_wait): flush_fd = flush_de = 1, all stall_* = 0; in DRAIN, next state RUN, counter cleared.
REQ-019 RUN with id_is_csr, no redirect, no mem_wait: enter DRAIN next cycle, counter = CSR_DRAIN_CYCLES; this cycle stall_pc = stall_fd = 1, flush_de = 1.
REQ-020 DRAIN, no redirect, no mem_wait: stall_pc = stall_fd = 1, flush_de = 1, counter decrements; at counter == 1, next state RUN and stalls release the following cycle, letting the CSR op enter execute.
REQ-021 Load-use (RUN only, no redirect/mem_wait/CSR): ex_is_load && ex_rd != 0 && ((id_uses_rs[0] && id_rs1 == ex_rd) || (id_uses_rs[1] && id_rs2 == ex_rd)) -> stall_pc = stall_fd = 1, flush_de = 1 for exactly that cycle.
REQ-022 ex_rd == 0 never creates a load-use hazard.
REQ-023 CSR arriving in RUN together with a load-use hazard: CSR rule governs; the drain bubbles cover the load latency.
REQ-024 Never assert stall and flush of the same register in one cycle.
REQ-025 No hazard: all outputs 0.

Reset
REQ-026 While nrst == 0 at posedge: state = RUN, counter = 0, perf counters = 0.
REQ-027 Outputs during/after reset are the RUN-state function of inputs; reset mid-DRAIN returns to RUN with no residual bubbles.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN defined: add outputs perf_stall_cycles (32) counting cycles with stall_fd = 1 and perf_flush_events (32) counting cycles with ex_redirect && !mem_wait, both saturating at 0xFFFFFFFF, cleared by reset.
REQ-029 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-030 ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs=2'b10 -> one cycle stall_fd=1, flush_de=1; ex_rd=0 same case -> all outputs 0.
REQ-031 id_is_csr=1 in RUN, CSR_DRAIN_CYCLES=3 -> stall_fd=1/flush_de=1 for 4 consecutive cycles, 0 on 5th.
REQ-032 mem_req=1, mem_ready=0 for 6 cycles during DRAIN -> all stalls 1, flushes 0, counter frozen; drain resumes where it paused.
REQ-033 ex_redirect=1 together with load-use hazard -> flush_fd=flush_de=1, stall_fd=0; in DRAIN -> RUN next cycle.
REQ-034 nrst=0 for one cycle mid-DRAIN -> RUN next cycle, stall_fd=0 with idle inputs; PIPE_CTRL_PERF_EN build: counters read 0.
